// File: rtl/rf_read_port_if.sv
// rtl/rf_read_port_if.sv - handshake, write-snoop and bitline bundle for rf_read_port
// Purpose: groups every non-clock/reset signal of the read-port controller.
// Signals:
//   req_valid/req_ready/req_addr        read request channel
//   wr_en/wr_addr/wr_data               array write strobe, snooped for forwarding
//   read_enable                         one-hot wordlines to the cell rows
//   bitline                             resolved bitline bus from the array
//   rsp_valid/rsp_ready/rsp_data/rsp_err read response channel
// Modports: slave = rf_read_port, master = requester plus array side.
interface rf_read_port_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int NUM_REGS   = 16
);
   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [NUM_REGS-1:0]   read_enable;
   logic [DATA_WIDTH-1:0] bitline;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_data;
   logic                  rsp_err;

   modport slave (
      input  req_valid, req_addr, wr_en, wr_addr, wr_data, bitline, rsp_ready,
      output req_ready, read_enable, rsp_valid, rsp_data, rsp_err
   );

   modport master (
      output req_valid, req_addr, wr_en, wr_addr, wr_data, bitline, rsp_ready,
      input  req_ready, read_enable, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - read-side controller for the register-file bit-cell array
// Purpose: accepts read requests, drives one-hot ReadEnable wordlines from a
// registered drive stage (S1), samples the bitline bus into a registered
// response stage (OUT).
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  rf_read_port_if.slave (request, write snoop, wordlines, bitlines, response)
// Optional: RF_READ_BYPASS_EN forwards a write that hits the row being sampled.
module rf_read_port #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int NUM_REGS   = 16
) (
   input logic           clk,
   input logic           rst,
   rf_read_port_if.slave bus
);

   logic                  s1_valid_q, s1_valid_d;
   logic [ADDR_WIDTH-1:0] s1_addr_q,  s1_addr_d;
   logic [NUM_REGS-1:0]   re_q,       re_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_data_q,  rsp_data_d;
   logic                  rsp_err_q,   rsp_err_d;

   logic out_free;
   logic s1_adv;
   logic accept;
   logic s1_in_range;
   logic bypass_hit;

   // Out-of-range addresses decode to all-zero so the bitlines float.
   function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_WIDTH-1:0] a);
      logic [NUM_REGS-1:0] r;
      for (int i = 0; i < NUM_REGS; i++) begin
         r[i] = (int'(a) == i);
      end
      return r;
   endfunction

   assign out_free    = !rsp_valid_q || bus.rsp_ready;
   assign s1_adv      = s1_valid_q && out_free;
   // Gated by rst so nothing is accepted while reset is held.
   assign bus.req_ready = rst && (!s1_valid_q || s1_adv);
   assign accept      = bus.req_valid && bus.req_ready;
   assign s1_in_range = int'(s1_addr_q) < NUM_REGS;

`ifdef RF_READ_BYPASS_EN
   // A cell drives its old value during a write, so a hit must take wr_data.
   assign bypass_hit = bus.wr_en && (bus.wr_addr == s1_addr_q);
`else
   logic unused_wr;
   assign unused_wr  = ^{bus.wr_en, bus.wr_addr, bus.wr_data};
   assign bypass_hit = 1'b0;
`endif

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_addr_d   = s1_addr_q;
      re_d        = re_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;

      // Wordlines are a register of their own, loaded alongside S1, so they
      // never glitch while the address decode settles.
      if (accept) begin
         s1_valid_d = 1'b1;
         s1_addr_d  = bus.req_addr;
         re_d       = onehot(bus.req_addr);
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
         re_d       = '0;
      end

      if (s1_adv) begin
         rsp_valid_d = 1'b1;
         if (!s1_in_range) begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
         end else if (bypass_hit) begin
            rsp_data_d = bus.wr_data;
            rsp_err_d  = 1'b0;
         end else begin
            rsp_data_d = bus.bitline;
            rsp_err_d  = 1'b0;
         end
      end else if (bus.rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q  <= 1'b0;
         s1_addr_q   <= '0;
         re_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_addr_q   <= s1_addr_d;
         re_q        <= re_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign bus.read_enable = re_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_data    = rsp_data_q;
   assign bus.rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_rf_read_port.sv
// tb/tb_rf_read_port.sv - directed scoreboard bench for rf_read_port
module tb_rf_read_port;
   localparam int DW = 16;
   localparam int AW = 4;
   localparam int NR = 12;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rf_read_port_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) bus ();

   rf_read_port #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int total = 0;
   int bad   = 0;
   logic [DW:0] exp_q [$];
   logic [DW:0] e;

   // Array model: write commits on the edge; cells show the stored value.
   logic [DW-1:0] mem [16];
   always @(posedge clk) begin
      if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
   end

   always_comb begin
      bus.bitline = '0;
      for (int i = 0; i < NR; i++) begin
         if (bus.read_enable[i]) bus.bitline = mem[i];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] d, input logic err);
      exp_q.push_back({err, d});
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = d;
      tick();
      bus.wr_en = 1'b0;
   endtask

   task automatic req(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic err);
      bus.req_valid = 1'b1;
      bus.req_addr  = a;
      #1;
      chk("req_ready_on_req", {31'd0, bus.req_ready}, 32'd1);
      push(d, err);
      @(posedge clk);
      #1;
   endtask

   // Response scoreboard and wordline one-hot check, sampled mid-cycle.
   always @(negedge clk) begin
      total++;
      assert ($onehot0(bus.read_enable)) else begin
         bad++;
         $error("FAIL re_onehot observed=%h expected=onehot0", bus.read_enable);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
         total++;
         assert (exp_q.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_rsp observed=%h expected=none", bus.rsp_data);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            assert (bus.rsp_data === e[DW-1:0]) else begin
               bad++;
               $error("FAIL rsp_data observed=%h expected=%h", bus.rsp_data, e[DW-1:0]);
            end
            total++;
            assert (bus.rsp_err === e[DW]) else begin
               bad++;
               $error("FAIL rsp_err observed=%b expected=%b", bus.rsp_err, e[DW]);
            end
         end
      end
   end

   initial begin
      rst           = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.wr_en     = 1'b0;
      bus.wr_addr   = '0;
      bus.wr_data   = '0;
      bus.rsp_ready = 1'b0;
      #1 rst = 1'b0;
      #2;
      chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("rst_read_enable", {20'd0, bus.read_enable}, 32'd0);
      chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("rst_rsp_data", {16'd0, bus.rsp_data}, 32'd0);
      chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
      tick();
      tick();
      rst = 1'b1;
      wr(4'd3, 16'hA5A5);
      wr(4'd1, 16'h0001);
      wr(4'd2, 16'h0002);
      wr(4'd5, 16'h1111);
      wr(4'd4, 16'h4444);
      wr(4'd7, 16'h00FF);
      wr(4'd11, 16'h0B0B);

      // Single read, latency and one-cycle wordline.
      bus.rsp_ready = 1'b1;
      req(4'd3, 16'hA5A5, 1'b0);
      bus.req_valid = 1'b0;
      chk("t1_re", {20'd0, bus.read_enable}, 32'h0008);
      chk("t1_valid_early", {31'd0, bus.rsp_valid}, 32'd0);
      tick();
      chk("t1_re_off", {20'd0, bus.read_enable}, 32'h0);
      chk("t1_valid", {31'd0, bus.rsp_valid}, 32'd1);
      tick();
      chk("t1_valid_clear", {31'd0, bus.rsp_valid}, 32'd0);

      // Back-to-back rows 1, 2, 3.
      wr(4'd3, 16'h0003);
      for (int k = 1; k <= 3; k++) begin
         req(AW'(k), DW'(k), 1'b0);
         chk("t2_re", {20'd0, bus.read_enable}, 32'd1 << k);
      end
      bus.req_valid = 1'b0;
      chk("t2_valid_stream", {31'd0, bus.rsp_valid}, 32'd1);
      tick();
      tick();
      tick();

      // Stall with write landing on the stalled S1 row.
      bus.rsp_ready = 1'b0;
      req(4'd4, 16'h4444, 1'b0);
      req(4'd5, 16'h2222, 1'b0);
      bus.req_valid = 1'b0;
      chk("t3_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("t3_re", {20'd0, bus.read_enable}, 32'h0020);
      chk("t3_ready", {31'd0, bus.req_ready}, 32'd0);
      wr(4'd5, 16'h2222);
      chk("t3_re_stall", {20'd0, bus.read_enable}, 32'h0020);
      chk("t3_ready_stall", {31'd0, bus.req_ready}, 32'd0);
      chk("t3_hold", {16'd0, bus.rsp_data}, 32'h4444);
      tick();
      chk("t3_re_stall2", {20'd0, bus.read_enable}, 32'h0020);
      chk("t3_hold2", {16'd0, bus.rsp_data}, 32'h4444);
      bus.rsp_ready = 1'b1;
      #1;
      chk("t3_ready_release", {31'd0, bus.req_ready}, 32'd1);
      tick();
      chk("t3_re_off", {20'd0, bus.read_enable}, 32'h0);
      tick();
      tick();

      // Same-cycle write to the row being sampled.
`ifdef RF_READ_BYPASS_EN
      req(4'd7, 16'hBEEF, 1'b0);
`else
      req(4'd7, 16'h00FF, 1'b0);
`endif
      bus.req_valid = 1'b0;
      bus.wr_en   = 1'b1;
      bus.wr_addr = 4'd7;
      bus.wr_data = 16'hBEEF;
      tick();
      bus.wr_en = 1'b0;
      chk("t4_valid", {31'd0, bus.rsp_valid}, 32'd1);
      tick();

      // Out-of-range addresses and the last valid row.
      req(4'd13, 16'h0000, 1'b1);
      bus.req_valid = 1'b0;
      chk("t5_re13", {20'd0, bus.read_enable}, 32'h0);
      tick();
      chk("t5_err", {31'd0, bus.rsp_err}, 32'd1);
      tick();
      req(4'd12, 16'h0000, 1'b1);
      chk("t5_re12", {20'd0, bus.read_enable}, 32'h0);
      req(4'd11, 16'h0B0B, 1'b0);
      bus.req_valid = 1'b0;
      chk("t5_re11", {20'd0, bus.read_enable}, 32'h0800);
      tick();
      tick();
      tick();

      // Asynchronous reset with S1 and OUT both full.
      bus.rsp_ready = 1'b0;
      req(4'd1, 16'h0001, 1'b0);
      req(4'd2, 16'h0002, 1'b0);
      bus.req_valid = 1'b0;
      chk("t6_valid_pre", {31'd0, bus.rsp_valid}, 32'd1);
      chk("t6_re_pre", {20'd0, bus.read_enable}, 32'h0004);
      #2;
      rst = 1'b0;
      #1;
      chk("t6_valid_rst", {31'd0, bus.rsp_valid}, 32'd0);
      chk("t6_re_rst", {20'd0, bus.read_enable}, 32'h0);
      chk("t6_ready_rst", {31'd0, bus.req_ready}, 32'd0);
      chk("t6_data_rst", {16'd0, bus.rsp_data}, 32'h0);
      exp_q.delete();
      tick();
      bus.rsp_ready = 1'b1;
      rst = 1'b1;
      tick();
      tick();
      chk("t6_no_stale", {31'd0, bus.rsp_valid}, 32'd0);
      req(4'd2, 16'h0002, 1'b0);
      bus.req_valid = 1'b0;
      tick();
      chk("t6_valid_new", {31'd0, bus.rsp_valid}, 32'd1);
      tick();
      tick();

      chk("sb_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rf_read_port.md
Name: rf_read_port

Overview:
- Read-side controller for the register-file bit-cell array.
- Accepts read requests on a valid/ready handshake and drives the one-hot per-row ReadEnable wordlines.
- Samples the shared tri-state bitline bus and returns registered data on a valid/ready response channel.
- Optionally forwards a same-cycle write, because a bit cell drives its old stored value during the write cycle.

Parameters:
DATA_WIDTH, 16, bits per register (bitline bus width)
ADDR_WIDTH, 4, register address width
NUM_REGS, 16, number of rows; must be <= 2**ADDR_WIDTH

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset asserted)
req_valid  input  1  read request valid
req_ready  output  1  request accepted when req_valid && req_ready
req_addr  input  ADDR_WIDTH  register to read
wr_en  input  1  array write strobe (same signal the cells see), used for bypass
wr_addr  input  ADDR_WIDTH  array write address
wr_data  input  DATA_WIDTH  array write data
read_enable  output  NUM_REGS  one-hot wordlines to the cells' ReadEnable
bitline  input  DATA_WIDTH  resolved bitline bus from the array
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumed when rsp_valid && rsp_ready
rsp_data  output  DATA_WIDTH  read data
rsp_err  output  1  address was >= NUM_REGS

Behaviour:
- Two registered stages: S1 (drive) holds s1_valid and s1_addr; OUT holds rsp_valid, rsp_data and rsp_err.
- Reset (rst=0, asynchronous) clears s1_valid and rsp_valid, and sets rsp_data=0, rsp_err=0.
- While in reset, read_enable=0 and req_ready=0.
- out_free = !rsp_valid || rsp_ready.
- s1_adv = s1_valid && out_free.
- req_ready = !s1_valid || s1_adv.
- Accept: on accept, S1 loads req_addr and s1_valid is set at the next edge.
- read_enable = one-hot(s1_addr) when s1_valid and s1_addr < NUM_REGS; all-zero otherwise, so the bitlines float.
- read_enable is driven from registered state only and is glitch-free.
- At most one read_enable bit is high in any cycle.
- Sampling: on s1_adv, OUT loads one of:
  - wr_data, if bypass is enabled and wr_en && wr_addr == s1_addr;
  - otherwise bitline;
  - 0 with rsp_err=1 when s1_addr >= NUM_REGS.
- rsp_valid is set on the same edge.
- If rsp_ready is taken with no s1_adv, rsp_valid clears.
- Latency: request accepted at edge N; read_enable is high during cycle N..N+1; rsp_valid is high after edge N+1. That is 2 edges from accept to valid.
- Throughput: 1 read per cycle while rsp_ready=1.
- Stall (rsp_valid && !rsp_ready):
  - S1 holds and read_enable stays asserted;
  - sampling is deferred, so a write that lands during the stall is seen when S1 finally advances;
  - bypass is evaluated in the advance cycle only.
- OUT holds data stable while rsp_valid && !rsp_ready.
- Simultaneous accept and advance in one cycle is legal (pipelined back-to-back).
- Reset mid-operation discards in-flight S1/OUT contents; no response is produced for them.
- No combinational path from req_valid to req_ready. rsp_ready does reach req_ready combinationally, which is intentional.

Optional Feature:
RF_READ_BYPASS_EN
- Defined: same-cycle write forwarding as above. The response always reflects the array value after any write committed in the sampling cycle.
- Undefined: OUT always loads bitline (or 0 on rsp_err). wr_en, wr_addr and wr_data are unused. A read sampled in the same cycle as a write to that row returns the pre-write value.

Test Plan:
- Reset, then preload row 3 = 0xA5A5. Send req_addr=3 with rsp_ready=1 -> read_enable=0x0008 for exactly one cycle; rsp_valid 2 edges after accept with rsp_data=0xA5A5, rsp_err=0.
- Back-to-back requests for rows 1, 2, 3 (values 0x0001/0x0002/0x0003) with rsp_ready=1 -> three consecutive responses in order; req_ready stays 1.
- Hold rsp_ready=0 with OUT full and S1 = row 5 (0x1111). Write row 5 = 0x2222 during the stall, then release -> second response 0x2222. read_enable stays 0x0020 for the whole stall and req_ready=0.
- Request row 7 (0x00FF) with wr_en=1, wr_addr=7, wr_data=0xBEEF in the S1 cycle -> with RF_READ_BYPASS_EN: rsp_data=0xBEEF; without it: rsp_data=0x00FF.
- Parameters NUM_REGS=12, ADDR_WIDTH=4; request addr=13 -> read_enable stays 0; response rsp_data=0, rsp_err=1.
- Assert rst=0 asynchronously while S1 and OUT are both valid -> rsp_valid and read_enable drop immediately. After release, no stale response appears; the first new request returns correct data.
